phase_sequencer: RTL

- Owns the intersection phase register and car-request latches; answers the light controller's phase requests.
- Consumes the controller's timer-expiry flags (setbit) and proposed next phase (nextstate).
- Decides when the phase actually advances and issues the timer-restart pulse back to the controller.
- Gives the controller a synthesizable partner for its state/timer interface; short car-sensor pulses are never lost.

---
 rtl/phase_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Phase register and car-request latches partnering the light controller's state/timer interface.
// Advances on controller timer expiry, blanks re-advance while the timer restart pulse is high.
module phase_sequencer #(
   parameter logic [1:0]  REST_STATE  = 2'b00,
   parameter logic [1:0]  SERVE_STATE = 2'b10,
   parameter int unsigned CLR_LEN     = 1,
   parameter int unsigned WAIT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              car2,
   input  logic              car4,
   input  logic [3:0]        setbit,
   input  logic [1:0]        nextstate,
   output logic [1:0]        state,
   output logic              timer_clr,
   output logic              car2_pend,
   output logic              car4_pend,
   output logic [7:0]        phase_cnt,
   output logic [WAIT_W-1:0] wait_cnt
);

   localparam logic [2:0]        ClrLoad = 3'(CLR_LEN);
   localparam logic [WAIT_W-1:0] WaitMax = '1;
   localparam logic [WAIT_W-1:0] WaitOne = {{(WAIT_W-1){1'b0}}, 1'b1};

   logic              car2_sync1_q, car2_sync2_q, car2_prev_q;
   logic              car4_sync1_q, car4_sync2_q, car4_prev_q;
   logic [1:0]        state_q, state_d;
   logic [2:0]        clr_cnt_q, clr_cnt_d;
   logic              car2_pend_q, car2_pend_d;
   logic              car4_pend_q, car4_pend_d;
   logic [7:0]        phase_cnt_q, phase_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic in_rest, any_pend, advance_ok, enter_serve, car2_rise, car4_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         car2_sync1_q <= 1'b0;
         car2_sync2_q <= 1'b0;
         car2_prev_q  <= 1'b0;
         car4_sync1_q <= 1'b0;
         car4_sync2_q <= 1'b0;
         car4_prev_q  <= 1'b0;
         state_q      <= REST_STATE;
         clr_cnt_q    <= 3'd0;
         car2_pend_q  <= 1'b0;
         car4_pend_q  <= 1'b0;
         phase_cnt_q  <= 8'd0;
         wait_cnt_q   <= '0;
      end else begin
         car2_sync1_q <= car2;
         car2_sync2_q <= car2_sync1_q;
         car2_prev_q  <= car2_sync2_q;
         car4_sync1_q <= car4;
         car4_sync2_q <= car4_sync1_q;
         car4_prev_q  <= car4_sync2_q;
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         car2_pend_q  <= car2_pend_d;
         car4_pend_q  <= car4_pend_d;
         phase_cnt_q  <= phase_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      phase_cnt_d = phase_cnt_q;
      wait_cnt_d  = wait_cnt_q;

      in_rest    = (state_q == REST_STATE);
      any_pend   = car2_pend_q | car4_pend_q;
      // A nonzero restart countdown is the blanking window against stale setbit.
      advance_ok = enable & (|setbit) & (clr_cnt_q == 3'd0) & (nextstate != state_q) &
                   (~in_rest | any_pend);
      enter_serve = advance_ok & (nextstate == SERVE_STATE);

      if (advance_ok) begin
         state_d     = nextstate;
         phase_cnt_d = phase_cnt_q + 8'd1;
         clr_cnt_d   = ClrLoad;
      end else if (clr_cnt_q != 3'd0) begin
         clr_cnt_d = clr_cnt_q - 3'd1;
      end

      // A rise seen on the serve-entry edge beats the clear so the request survives.
      car2_rise   = car2_sync2_q & ~car2_prev_q;
      car4_rise   = car4_sync2_q & ~car4_prev_q;
      car2_pend_d = car2_rise | (car2_pend_q & ~enter_serve);
      car4_pend_d = car4_rise | (car4_pend_q & ~enter_serve);

      if (advance_ok && in_rest) begin
         wait_cnt_d = '0;
      end else if (in_rest && any_pend && (wait_cnt_q != WaitMax)) begin
         wait_cnt_d = wait_cnt_q + WaitOne;
      end
   end

   assign state     = state_q;
   assign timer_clr = (clr_cnt_q != 3'd0);
   assign car2_pend = car2_pend_q;
   assign car4_pend = car4_pend_q;
   assign phase_cnt = phase_cnt_q;
   assign wait_cnt  = wait_cnt_q;

endmodule
